// File: rtl/qq_op_arbiter.sv
// -----------------------------------------------------------------------------
// qq_op_arbiter
// Shares one QuickQ priority-queue controller between N_REQ requesters.
// A round-robin pick selects one requester. Its operation is checked against
// the queue full/empty flags and then issued to the controller as a single
// enq or deq pulse. The arbiter waits for done, or gives up after TIMEOUT
// cycles, and returns an ack or an error to the winner.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req[N_REQ]          per-requester level request
//   i_req_deq[N_REQ]      per-requester op (1 = dequeue, 0 = enqueue)
//   i_req_data            per-requester enqueue data, slice i = [i*DW +: DW]
//   o_gnt[N_REQ]          one-hot acceptance pulse
//   o_rsp_valid[N_REQ]    one-hot response pulse
//   o_rsp_err             response is a reject (full/empty) or a timeout
//   o_rsp_data            dequeued entry on a successful dequeue
//   o_enq, o_deq          one-cycle operation pulses to the controller
//   o_q_wdata             enqueue data, held from the pulse until the response
//   i_done                controller operation complete
//   i_full, i_empty       queue status flags
//   i_q_rdata             controller dequeue output, sampled with i_done
// -----------------------------------------------------------------------------
module qq_op_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [N_REQ-1:0]    i_req,
   input  logic [N_REQ-1:0]    i_req_deq,
   input  logic [N_REQ*DW-1:0] i_req_data,
   output logic [N_REQ-1:0]    o_gnt,
   output logic [N_REQ-1:0]    o_rsp_valid,
   output logic                o_rsp_err,
   output logic [DW-1:0]       o_rsp_data,
   output logic                o_enq,
   output logic                o_deq,
   output logic [DW-1:0]       o_q_wdata,
   input  logic                i_done,
   input  logic                i_full,
   input  logic                i_empty,
   input  logic [DW-1:0]       i_q_rdata
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Round-robin pick: the first requesting index at or after ptr, wrapping.
   // The scan runs from the farthest candidate back to the nearest, so the
   // last hit that is kept is the nearest one.
   function automatic logic [IW-1:0] f_rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IW-1:0]    ptr);
      logic [IW-1:0] pick;
      int            c;
      pick = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         c = int'(ptr) + k;
         if (c >= N_REQ) begin
            c = c - N_REQ;
         end else begin
            c = c;
         end
         if (req[c]) begin
            pick = c[IW-1:0];
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   function automatic logic [N_REQ-1:0] f_onehot(input logic [IW-1:0] idx);
      return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   state_t            r_state,    w_state;
   logic [IW-1:0]     r_idx,      w_idx;
   logic              r_op,       w_op;
   logic [IW-1:0]     r_rr_ptr,   w_rr_ptr;
   logic [TW-1:0]     r_timer,    w_timer;
   logic [N_REQ-1:0]  r_gnt,      w_gnt;
   logic [N_REQ-1:0]  r_rsp_valid, w_rsp_valid;
   logic              r_rsp_err,  w_rsp_err;
   logic [DW-1:0]     r_rsp_data, w_rsp_data;
   logic              r_enq,      w_enq;
   logic              r_deq,      w_deq;
   logic [DW-1:0]     r_q_wdata,  w_q_wdata;
   logic [IW-1:0]     w_pick;
   logic              w_reject;

   assign w_pick   = f_rr_pick(i_req, r_rr_ptr);
   // An op is rejected up front when the queue cannot accept it.
   assign w_reject = r_op ? i_empty : i_full;

   // Next-state and next-output logic for the arbitration sequence.
   always_comb begin
      w_state     = r_state;
      w_idx       = r_idx;
      w_op        = r_op;
      w_rr_ptr    = r_rr_ptr;
      w_timer     = r_timer;
      w_gnt       = '0;
      w_rsp_valid = '0;
      w_rsp_err   = 1'b0;
      w_rsp_data  = r_rsp_data;
      w_enq       = 1'b0;
      w_deq       = 1'b0;
      w_q_wdata   = r_q_wdata;

      case (r_state)
         S_IDLE: begin
            if (|i_req) begin
               w_idx     = w_pick;
               w_op      = i_req_deq[w_pick];
               w_q_wdata = i_req_data[w_pick*DW +: DW];
               w_gnt     = f_onehot(w_pick);
               w_state   = S_CHECK;
            end else begin
               w_state   = S_IDLE;
            end
         end
         S_CHECK: begin
            if (w_reject) begin
               w_rsp_valid = f_onehot(r_idx);
               w_rsp_err   = 1'b1;
               w_rsp_data  = '0;
               w_state     = S_RESP;
            end else begin
               w_enq       = ~r_op;
               w_deq       = r_op;
               w_timer     = '0;
               w_state     = S_WAIT;
            end
         end
         S_WAIT: begin
            // The timer saturates so that it cannot wrap if the wait is stretched.
            if (r_timer == {TW{1'b1}}) begin
               w_timer = r_timer;
            end else begin
               w_timer = r_timer + {{(TW-1){1'b0}}, 1'b1};
            end
            // done is checked first, so it wins when it lands on the timeout cycle.
            if (i_done) begin
               w_rsp_valid = f_onehot(r_idx);
               w_rsp_err   = 1'b0;
               w_rsp_data  = r_op ? i_q_rdata : '0;
               w_state     = S_RESP;
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_rsp_valid = f_onehot(r_idx);
               w_rsp_err   = 1'b1;
               w_rsp_data  = '0;
               w_state     = S_RESP;
            end else begin
               w_state     = S_WAIT;
            end
         end
         S_RESP: begin
            if (r_idx == IW'(N_REQ - 1)) begin
               w_rr_ptr = '0;
            end else begin
               w_rr_ptr = r_idx + {{(IW-1){1'b0}}, 1'b1};
            end
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers. Reset abandons any operation in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_op        <= 1'b0;
         r_rr_ptr    <= '0;
         r_timer     <= '0;
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_enq       <= 1'b0;
         r_deq       <= 1'b0;
         r_q_wdata   <= '0;
      end else begin
         r_state     <= w_state;
         r_idx       <= w_idx;
         r_op        <= w_op;
         r_rr_ptr    <= w_rr_ptr;
         r_timer     <= w_timer;
         r_gnt       <= w_gnt;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_err   <= w_rsp_err;
         r_rsp_data  <= w_rsp_data;
         r_enq       <= w_enq;
         r_deq       <= w_deq;
         r_q_wdata   <= w_q_wdata;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_data  = r_rsp_data;
   assign o_enq       = r_enq;
   assign o_deq       = r_deq;
   assign o_q_wdata   = r_q_wdata;

endmodule
